decode_execute_register: RTL and testbench
==========================================

# decode_execute_register

Pipeline register between decode and execute in the pipelined core. It captures the two operands read combinationally from the register file, together with the decoded instruction fields, and presents them to execute one cycle later. The register file writes on the clock edge, so a same-cycle read returns the old value; this block supplies the missing write-through bypass. It also keeps a held (stalled) operand coherent with later writebacks, forces x0 reads to zero, and implements stall and flush.

## Interface
- ADDRESS_WIDTH, 5, register address width
- DATA_WIDTH, 32, operand/PC/immediate width
- CTRL_WIDTH, 12, width of packed control bundle (pipeline_pkg::ctrl_t)
- COUNT_WIDTH, 16, stall/bubble counter width

- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  reset, asynchronous, active-low
- ValidD  in  1  decode slot holds a real instruction
- StallE  in  1  hold all E-side state this cycle
- FlushE  in  1  load a bubble this cycle
- Rs1D, Rs2D, RdD  in  ADDRESS_WIDTH  source/dest addresses
- RD1D, RD2D  in  DATA_WIDTH  register file read data
- PCD, ImmExtD  in  DATA_WIDTH  PC and extended immediate
- CtrlD  in  CTRL_WIDTH  decoded control bundle
- WE3W  in  1  writeback enable, same signal driven to register file
- A3W  in  ADDRESS_WIDTH  writeback address
- WD3W  in  DATA_WIDTH  writeback data
- ValidE  out  1  execute slot valid
- Rs1E, Rs2E, RdE  out  ADDRESS_WIDTH  registered addresses
- RD1E, RD2E  out  DATA_WIDTH  registered, coherent operands
- PCE, ImmExtE  out  DATA_WIDTH  registered PC/immediate
- CtrlE  out  CTRL_WIDTH  registered control; all-zero for a bubble
- StallCount, BubbleCount  out  COUNT_WIDTH  saturating event counters

## Operation
- Per-edge priority: reset > FlushE > StallE > load.
- Load (no flush, no stall): every E register takes its D input. ValidE takes ValidD. Operand n is selected as follows:
  - 0 if RsnD == 0
  - else WD3W if WE3W && A3W == RsnD
  - else RDnD
- Flush: ValidE=0, CtrlE=0, and every address/data output is 0. FlushE with StallE asserted still flushes.
- Stall: all E registers hold, with one exception for coherence. If WE3W && A3W != 0 && A3W == RsnE, RDnE takes WD3W. The address match uses RsnE, not RsnD.
- A3W == 0 never updates or bypasses an operand.
- Bubble semantics: CtrlE all-zero means RegWrite=0 and MemWrite=0, so downstream stages need no extra gating.
- StallCount increments on each edge with StallE=1 and FlushE=0. BubbleCount increments on each edge that loads ValidE=0 (flush, or load with ValidD=0). Both counters saturate at all-ones. They are cleared only by reset.

## Timing
- Latency: D inputs sampled at edge N appear on E outputs after edge N, stable for cycle N+1.
- Outputs are pure register outputs; there is no combinational path from inputs to outputs.
- Reset (rst_n low, any time, asynchronous) sets every output and counter to 0.
- Deassertion is synchronised externally. The first load occurs on the first posedge with rst_n high.
- Reset mid-stall discards the held instruction; there is no replay.
- Simultaneous bypass and x0: the x0 rule wins and the operand is 0.
- Writeback to Rs1 and Rs2 in the same cycle with Rs1==Rs2: both operands take WD3W.
- Counter saturation: at all-ones the counter stays all-ones; it does not wrap.

## Structure
- pipeline_pkg holds:
  - typedef ctrl_t: packed struct of RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc, ImmSrc[1:0]
  - CTRL_WIDTH = $bits(ctrl_t)
  - REG_ZERO constant
  - CTRL_BUBBLE constant (all-zero)
- Sub-module operand_capture holds one operand register with the x0/bypass/stall-refresh logic. It is instantiated twice, for Rs1 and Rs2.
- The top module contains the plain pipeline registers and the two saturating counters.

## Test plan
- Reset check: assert rst_n=0 mid-cycle with nonzero state. Every output and counter reads 0 immediately, before the next edge.
- Bypass on load: Rs1D=5, RD1D=0x11, WE3W=1, A3W=5, WD3W=0xAA. After the edge, RD1E=0xAA and RD2E equals RD2D.
- x0 reads: Rs2D=0, RD2D=0xDEAD, WE3W=1, A3W=0. After the edge, RD2E=0.
- Stall refresh: load Rs1E=7/RD1E=0x1, then StallE=1 for 3 cycles with a WE3W write of 0x77 to x7 in cycle 2. RD1E=0x77 and all other outputs stay unchanged. StallCount increases by 3.
- Flush beats stall: StallE=1, FlushE=1. After the edge, ValidE=0, CtrlE=0, RD1E=0, BubbleCount increases by 1, and StallCount is unchanged.
- Saturation: hold StallE for 2^COUNT_WIDTH+5 cycles. StallCount reads 0xFFFF and stays there.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types: the packed control bundle carried from decode to
// execute, plus the constants the D/E register uses for x0 and bubbles.
package pipeline_pkg;

   typedef struct packed {
      logic       RegWrite;
      logic [1:0] ResultSrc;
      logic       MemWrite;
      logic       Jump;
      logic       Branch;
      logic [2:0] ALUControl;
      logic       ALUSrc;
      logic [1:0] ImmSrc;
   } ctrl_t;

   localparam int          CTRL_WIDTH  = $bits(ctrl_t);
   localparam int unsigned REG_ZERO    = 0;
   // All-zero control: RegWrite=0 and MemWrite=0, so a bubble is inert downstream.
   localparam ctrl_t       CTRL_BUBBLE = '0;

   typedef enum logic [1:0] {
      OPND_ZERO,
      OPND_BYPASS,
      OPND_RF
   } opnd_src_e;

endpackage

// File: rtl/operand_capture.sv
// One E-stage operand register: x0 forcing, write-through bypass on load,
// and refresh of a held operand when a matching writeback lands during a stall.
module operand_capture #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     stall,
   input  logic [ADDRESS_WIDTH-1:0] rs_d,
   input  logic [ADDRESS_WIDTH-1:0] rs_e,
   input  logic [DATA_WIDTH-1:0]    rd_d,
   input  logic                     we,
   input  logic [ADDRESS_WIDTH-1:0] wa,
   input  logic [DATA_WIDTH-1:0]    wd,
   output logic [DATA_WIDTH-1:0]    rd_e
);
   import pipeline_pkg::*;

   localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

   opnd_src_e load_src;
   logic      refresh;

   // x0 is checked first so a writeback aimed at x0 can never leak through.
   always_comb begin
      load_src = OPND_RF;
      if (rs_d == ZERO_ADDR)
         load_src = OPND_ZERO;
      else if (we && (wa == rs_d))
         load_src = OPND_BYPASS;
   end

   // While held, the operand tracks writebacks to the register it was read from.
   assign refresh = we && (wa != ZERO_ADDR) && (wa == rs_e);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_e <= '0;
      end else if (flush) begin
         rd_e <= '0;
      end else if (stall) begin
         if (refresh)
            rd_e <= wd;
      end else begin
         unique case (load_src)
            OPND_ZERO:   rd_e <= '0;
            OPND_BYPASS: rd_e <= wd;
            default:     rd_e <= rd_d;
         endcase
      end
   end

endmodule

// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with flush/stall control, coherent
// operand capture and saturating stall/bubble event counters.
module decode_execute_register #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32,
   parameter int CTRL_WIDTH    = pipeline_pkg::CTRL_WIDTH,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     ValidD,
   input  logic                     StallE,
   input  logic                     FlushE,
   input  logic [ADDRESS_WIDTH-1:0] Rs1D,
   input  logic [ADDRESS_WIDTH-1:0] Rs2D,
   input  logic [ADDRESS_WIDTH-1:0] RdD,
   input  logic [DATA_WIDTH-1:0]    RD1D,
   input  logic [DATA_WIDTH-1:0]    RD2D,
   input  logic [DATA_WIDTH-1:0]    PCD,
   input  logic [DATA_WIDTH-1:0]    ImmExtD,
   input  logic [CTRL_WIDTH-1:0]    CtrlD,
   input  logic                     WE3W,
   input  logic [ADDRESS_WIDTH-1:0] A3W,
   input  logic [DATA_WIDTH-1:0]    WD3W,
   output logic                     ValidE,
   output logic [ADDRESS_WIDTH-1:0] Rs1E,
   output logic [ADDRESS_WIDTH-1:0] Rs2E,
   output logic [ADDRESS_WIDTH-1:0] RdE,
   output logic [DATA_WIDTH-1:0]    RD1E,
   output logic [DATA_WIDTH-1:0]    RD2E,
   output logic [DATA_WIDTH-1:0]    PCE,
   output logic [DATA_WIDTH-1:0]    ImmExtE,
   output logic [CTRL_WIDTH-1:0]    CtrlE,
   output logic [COUNT_WIDTH-1:0]   StallCount,
   output logic [COUNT_WIDTH-1:0]   BubbleCount
);
   import pipeline_pkg::*;

   logic stall_event;
   logic bubble_event;

   operand_capture #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_opnd1 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (FlushE),
      .stall (StallE),
      .rs_d  (Rs1D),
      .rs_e  (Rs1E),
      .rd_d  (RD1D),
      .we    (WE3W),
      .wa    (A3W),
      .wd    (WD3W),
      .rd_e  (RD1E)
   );

   operand_capture #(
      .ADDRESS_WIDTH (ADDRESS_WIDTH),
      .DATA_WIDTH    (DATA_WIDTH)
   ) u_opnd2 (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (FlushE),
      .stall (StallE),
      .rs_d  (Rs2D),
      .rs_e  (Rs2E),
      .rd_d  (RD2D),
      .we    (WE3W),
      .wa    (A3W),
      .wd    (WD3W),
      .rd_e  (RD2E)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ValidE  <= 1'b0;
         Rs1E    <= '0;
         Rs2E    <= '0;
         RdE     <= '0;
         PCE     <= '0;
         ImmExtE <= '0;
         CtrlE   <= '0;
      end else if (FlushE) begin
         ValidE  <= 1'b0;
         Rs1E    <= '0;
         Rs2E    <= '0;
         RdE     <= '0;
         PCE     <= '0;
         ImmExtE <= '0;
         CtrlE   <= CTRL_WIDTH'(CTRL_BUBBLE);
      end else if (!StallE) begin
         ValidE  <= ValidD;
         Rs1E    <= Rs1D;
         Rs2E    <= Rs2D;
         RdE     <= RdD;
         PCE     <= PCD;
         ImmExtE <= ImmExtD;
         CtrlE   <= CtrlD;
      end
   end

   // Flush outranks stall, so a flushed stall cycle counts only as a bubble.
   assign stall_event  = StallE && !FlushE;
   assign bubble_event = FlushE || (!StallE && !ValidD);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         StallCount  <= '0;
         BubbleCount <= '0;
      end else begin
         if (stall_event && !(&StallCount))
            StallCount <= StallCount + 1'b1;
         if (bubble_event && !(&BubbleCount))
            BubbleCount <= BubbleCount + 1'b1;
      end
   end

endmodule

// File: tb/tb_decode_execute_register.sv
// Bench for decode_execute_register: table of load/flush vectors plus
// hand-built stall, reset and counter-saturation sequences, via a scoreboard.
module tb_decode_execute_register;

   typedef struct {
      logic        valid, stall, flush;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rd1, rd2, pc, imm;
      logic [11:0] ctrl;
      logic        we;
      logic [4:0]  a3;
      logic [31:0] wd;
   } in_t;

   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rd1, rd2, pc, imm;
      logic [11:0] ctrl;
      logic [15:0] sc, bc;
   } exp_t;

   typedef struct {
      in_t         in;
      logic        e_valid;
      logic [31:0] e_rd1, e_rd2;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ValidD, StallE, FlushE, WE3W;
   logic [4:0]  Rs1D, Rs2D, RdD, A3W;
   logic [31:0] RD1D, RD2D, PCD, ImmExtD, WD3W;
   logic [11:0] CtrlD;
   logic        ValidE;
   logic [4:0]  Rs1E, Rs2E, RdE;
   logic [31:0] RD1E, RD2E, PCE, ImmExtE;
   logic [11:0] CtrlE;
   logic [15:0] StallCount, BubbleCount;

   int   checks   = 0;
   int   failures = 0;
   exp_t sbq[$];
   exp_t cur;
   vec_t vecs[10];

   always #5 clk = ~clk;

   decode_execute_register #(
      .ADDRESS_WIDTH (5),
      .DATA_WIDTH    (32),
      .CTRL_WIDTH    (12),
      .COUNT_WIDTH   (16)
   ) dut (
      .clk (clk), .rst_n (rst_n), .ValidD (ValidD), .StallE (StallE), .FlushE (FlushE),
      .Rs1D (Rs1D), .Rs2D (Rs2D), .RdD (RdD), .RD1D (RD1D), .RD2D (RD2D),
      .PCD (PCD), .ImmExtD (ImmExtD), .CtrlD (CtrlD),
      .WE3W (WE3W), .A3W (A3W), .WD3W (WD3W),
      .ValidE (ValidE), .Rs1E (Rs1E), .Rs2E (Rs2E), .RdE (RdE),
      .RD1E (RD1E), .RD2E (RD2E), .PCE (PCE), .ImmExtE (ImmExtE), .CtrlE (CtrlE),
      .StallCount (StallCount), .BubbleCount (BubbleCount)
   );

   function automatic in_t mk(logic v, logic s, logic f, logic [4:0] r1, logic [4:0] r2,
                              logic [4:0] rd, logic [31:0] d1, logic [31:0] d2,
                              logic [31:0] pc, logic [31:0] imm, logic [11:0] c,
                              logic we, logic [4:0] a3, logic [31:0] wd);
      in_t i;
      i.valid = v; i.stall = s; i.flush = f; i.rs1 = r1; i.rs2 = r2; i.rd = rd;
      i.rd1 = d1; i.rd2 = d2; i.pc = pc; i.imm = imm; i.ctrl = c;
      i.we = we; i.a3 = a3; i.wd = wd;
      return i;
   endfunction

   function automatic logic [15:0] sat(logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic exp_t zero_exp();
      exp_t e;
      e.valid = 1'b0; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
      e.rd1 = '0; e.rd2 = '0; e.pc = '0; e.imm = '0; e.ctrl = '0;
      e.sc = '0; e.bc = '0;
      return e;
   endfunction

   // Expected state after a load or flush edge; operand values come from the caller.
   function automatic exp_t next_exp(in_t i, exp_t c, logic v, logic [31:0] r1, logic [31:0] r2);
      exp_t e;
      e = zero_exp();
      e.sc = c.sc;
      if (i.flush) begin
         e.bc = sat(c.bc);
      end else begin
         e.valid = v; e.rs1 = i.rs1; e.rs2 = i.rs2; e.rd = i.rd;
         e.rd1 = r1; e.rd2 = r2; e.pc = i.pc; e.imm = i.imm; e.ctrl = i.ctrl;
         e.bc = v ? c.bc : sat(c.bc);
      end
      return e;
   endfunction

   task automatic drive(input in_t i);
      ValidD = i.valid; StallE = i.stall; FlushE = i.flush;
      Rs1D = i.rs1; Rs2D = i.rs2; RdD = i.rd; RD1D = i.rd1; RD2D = i.rd2;
      PCD = i.pc; ImmExtD = i.imm; CtrlD = i.ctrl;
      WE3W = i.we; A3W = i.a3; WD3W = i.wd;
   endtask

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic check_head(input string tag);
      exp_t e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: scoreboard empty", tag);
         return;
      end
      e = sbq.pop_front();
      cmp({tag, ".ValidE"},      32'(ValidE),      32'(e.valid));
      cmp({tag, ".Rs1E"},        32'(Rs1E),        32'(e.rs1));
      cmp({tag, ".Rs2E"},        32'(Rs2E),        32'(e.rs2));
      cmp({tag, ".RdE"},         32'(RdE),         32'(e.rd));
      cmp({tag, ".RD1E"},        RD1E,             e.rd1);
      cmp({tag, ".RD2E"},        RD2E,             e.rd2);
      cmp({tag, ".PCE"},         PCE,              e.pc);
      cmp({tag, ".ImmExtE"},     ImmExtE,          e.imm);
      cmp({tag, ".CtrlE"},       32'(CtrlE),       32'(e.ctrl));
      cmp({tag, ".StallCount"},  32'(StallCount),  32'(e.sc));
      cmp({tag, ".BubbleCount"}, 32'(BubbleCount), 32'(e.bc));
   endtask

   task automatic step(input in_t i, input exp_t e, input string tag);
      drive(i);
      sbq.push_back(e);
      @(posedge clk);
      #1;
      check_head(tag);
   endtask

   initial begin
      in_t  i;
      exp_t e;

      vecs[0] = '{in: mk(1,0,0, 5, 6, 3, 32'h11, 32'h22, 32'h1000, 32'h4, 12'h801, 1, 5, 32'hAA),
                  e_valid: 1, e_rd1: 32'hAA, e_rd2: 32'h22};
      vecs[1] = '{in: mk(1,0,0, 4, 0, 2, 32'h44, 32'hDEAD, 32'h1004, 32'h8, 12'h0F0, 1, 0, 32'hBEEF),
                  e_valid: 1, e_rd1: 32'h44, e_rd2: 32'h0};
      vecs[2] = '{in: mk(1,0,0, 9, 9, 9, 32'h1, 32'h2, 32'h1008, 32'hC, 12'h123, 1, 9, 32'h1234),
                  e_valid: 1, e_rd1: 32'h1234, e_rd2: 32'h1234};
      vecs[3] = '{in: mk(1,0,0, 9, 1, 4, 32'h99, 32'h3, 32'h100C, 32'h10, 12'h456, 0, 9, 32'h5),
                  e_valid: 1, e_rd1: 32'h99, e_rd2: 32'h3};
      vecs[4] = '{in: mk(1,0,0, 0, 0, 1, 32'h55, 32'h56, 32'h1010, 32'h14, 12'hFFF, 1, 0, 32'h66),
                  e_valid: 1, e_rd1: 32'h0, e_rd2: 32'h0};
      vecs[5] = '{in: mk(0,0,0, 3, 8, 6, 32'h30, 32'h80, 32'h1014, 32'h18, 12'h321, 0, 0, 32'h0),
                  e_valid: 0, e_rd1: 32'h30, e_rd2: 32'h80};
      vecs[6] = '{in: mk(1,0,1, 3, 8, 6, 32'h30, 32'h80, 32'h1018, 32'h1C, 12'h801, 1, 3, 32'h77),
                  e_valid: 0, e_rd1: 32'h0, e_rd2: 32'h0};
      vecs[7] = '{in: mk(1,1,1, 3, 8, 6, 32'h30, 32'h80, 32'h101C, 32'h20, 12'h801, 1, 8, 32'h78),
                  e_valid: 0, e_rd1: 32'h0, e_rd2: 32'h0};
      vecs[8] = '{in: mk(1,0,0, 12, 13, 14, 32'hC0DE, 32'hF00D, 32'h1020, 32'h24, 12'h00A, 1, 15, 32'h9),
                  e_valid: 1, e_rd1: 32'hC0DE, e_rd2: 32'hF00D};
      vecs[9] = '{in: mk(1,0,0, 12, 13, 14, 32'hC0DE, 32'hF00D, 32'h1024, 32'h28, 12'h00B, 1, 13, 32'hABCD),
                  e_valid: 1, e_rd1: 32'hC0DE, e_rd2: 32'hABCD};

      rst_n = 1'b0;
      drive(mk(0,0,0, 0,0,0, 0,0,0,0, 0, 0,0,0));
      repeat (2) @(posedge clk);
      #1;
      cur = zero_exp();
      sbq.push_back(cur);
      check_head("reset");
      rst_n = 1'b1;

      for (int unsigned n = 0; n < 10; n++) begin
         cur = next_exp(vecs[n].in, cur, vecs[n].e_valid, vecs[n].e_rd1, vecs[n].e_rd2);
         step(vecs[n].in, cur, $sformatf("vec%0d", n));
      end

      // Stall refresh: only a writeback matching the held Rs1E (x7) may change RD1E.
      i = mk(1,0,0, 7, 8, 10, 32'h1, 32'h2, 32'h100, 32'h20, 12'hABC, 0, 0, 0);
      cur = next_exp(i, cur, 1, 32'h1, 32'h2);
      step(i, cur, "stall_load");
      i = mk(0,1,0, 12, 13, 1, 32'hF0, 32'hF1, 32'h200, 32'h40, 12'h123, 1, 12, 32'h55);
      cur.sc = sat(cur.sc);
      step(i, cur, "stall_c1");
      i.a3 = 7; i.wd = 32'h77;
      cur.sc = sat(cur.sc); cur.rd1 = 32'h77;
      step(i, cur, "stall_c2");
      i.rs1 = 0; i.a3 = 0; i.wd = 32'h99;
      cur.sc = sat(cur.sc);
      step(i, cur, "stall_c3");

      i = mk(1,1,1, 7, 8, 10, 32'h1, 32'h2, 32'h300, 32'h50, 12'hFFF, 1, 7, 32'h88);
      cur = next_exp(i, cur, 0, 0, 0);
      step(i, cur, "flush_stall");

      // Asynchronous reset in the middle of a stalled cycle.
      i = mk(1,0,0, 2, 3, 4, 32'h21, 32'h31, 32'h400, 32'h60, 12'h5A5, 0, 0, 0);
      cur = next_exp(i, cur, 1, 32'h21, 32'h31);
      step(i, cur, "pre_reset");
      i.stall = 1;
      cur.sc = sat(cur.sc);
      step(i, cur, "pre_reset_stall");
      #2;
      rst_n = 1'b0;
      #1;
      cur = zero_exp();
      sbq.push_back(cur);
      check_head("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      i = mk(0,0,0, 1, 1, 1, 32'h5, 32'h6, 32'h500, 32'h70, 12'h001, 0, 0, 0);
      cur = next_exp(i, cur, 0, 32'h5, 32'h6);
      step(i, cur, "post_reset");

      i.stall = 1;
      drive(i);
      for (int unsigned n = 0; n < 65541; n++) begin
         @(posedge clk);
         cur.sc = sat(cur.sc);
      end
      #1;
      sbq.push_back(cur);
      check_head("sat");
      cmp("sat_value", 32'(StallCount), 32'hFFFF);
      step(i, cur, "sat_hold");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
